// File: rtl/line_buffer_3row.sv
// line_buffer_3row
// Buffers a raster pixel stream into three rotating row slots. On each shift
// request it presents one vertically aligned column of three pixels, top row
// first. After a window row it reloads only the row slot that has become stale.
// Build option: define LINEBUF_UNDERRUN_CHECK_EN to enable the sticky
// err_underrun flag. When it is undefined, err_underrun is tied low.
module line_buffer_3row #(
    parameter int BIT_DEPTH  = 8,
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [BIT_DEPTH-1:0] pix_in,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    input  logic                 shift,
    output logic [BIT_DEPTH-1:0] out_l1,
    output logic [BIT_DEPTH-1:0] out_l2,
    output logic [BIT_DEPTH-1:0] out_l3,
    output logic                 out_valid,
    output logic                 rows_ready,
    output logic                 row_done,
    output logic                 frame_done,
    output logic                 err_underrun
);

    localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int RW = $clog2(IMG_HEIGHT + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FILL   = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_REFILL = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT);

    logic [2:0]           state;
    logic [CW-1:0]        wr_col;
    logic [CW-1:0]        rd_col;
    logic [1:0]           fill_slot;
    logic [1:0]           top_slot;
    logic [1:0]           mid_slot;
    logic [1:0]           bot_slot;
    logic [1:0]           wr_slot;
    logic [RW-1:0]        rows_loaded;
    logic                 pix_accept;
    logic                 wr_last;
    logic                 rd_last;
    logic [BIT_DEPTH-1:0] mem [3][IMG_WIDTH];

    // The slot order below the top row wraps modulo 3.
    assign mid_slot = (top_slot == 2'd2) ? 2'd0 : top_slot + 2'd1;
    assign bot_slot = (top_slot == 2'd0) ? 2'd2 : top_slot - 2'd1;

    // The initial fill walks slots 0..2. A refill overwrites the stale top slot.
    assign wr_slot    = (state == S_FILL) ? fill_slot : top_slot;
    assign pix_ready  = (state == S_FILL) || (state == S_REFILL);
    assign rows_ready = (state == S_STREAM);
    assign pix_accept = pix_valid && pix_ready;
    assign wr_last    = pix_accept && (wr_col == LAST_COL);
    assign rd_last    = (rd_col == LAST_COL);

    // Row storage has no reset. Its contents are rewritten before they are read.
    always_ff @(posedge clk) begin
        if (pix_accept) begin
            mem[wr_slot][wr_col] <= pix_in;
        end
    end

    // Frame sequencing, column read-out and slot rotation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            wr_col      <= '0;
            rd_col      <= '0;
            fill_slot   <= 2'd0;
            top_slot    <= 2'd0;
            rows_loaded <= '0;
            out_l1      <= '0;
            out_l2      <= '0;
            out_l3      <= '0;
            out_valid   <= 1'b0;
            row_done    <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            row_done   <= 1'b0;
            frame_done <= 1'b0;
            if (pix_accept) begin
                wr_col <= wr_last ? '0 : wr_col + 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_FILL;
                        fill_slot   <= 2'd0;
                        top_slot    <= 2'd0;
                        wr_col      <= '0;
                        rd_col      <= '0;
                        rows_loaded <= '0;
                    end
                end
                S_FILL: begin
                    if (wr_last) begin
                        if (fill_slot == 2'd2) begin
                            state       <= S_STREAM;
                            top_slot    <= 2'd0;
                            rows_loaded <= RW'(3);
                        end else begin
                            fill_slot <= fill_slot + 2'd1;
                        end
                    end
                end
                S_STREAM: begin
                    if (shift) begin
                        out_l1    <= mem[top_slot][rd_col];
                        out_l2    <= mem[mid_slot][rd_col];
                        out_l3    <= mem[bot_slot][rd_col];
                        out_valid <= 1'b1;
                        if (rd_last) begin
                            rd_col   <= '0;
                            row_done <= 1'b1;
                            state    <= (rows_loaded == LAST_ROW) ? S_DONE : S_REFILL;
                        end else begin
                            rd_col <= rd_col + 1'b1;
                        end
                    end
                end
                S_REFILL: begin
                    if (wr_last) begin
                        top_slot    <= mid_slot;
                        rows_loaded <= rows_loaded + 1'b1;
                        state       <= S_STREAM;
                    end
                end
                S_DONE: begin
                    frame_done <= 1'b1;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef LINEBUF_UNDERRUN_CHECK_EN
    // Sticky flag for a shift request that arrives while no column is available.
    // A new underrun wins over the clear from an accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_underrun <= 1'b0;
        end else if (shift && (state != S_STREAM)) begin
            err_underrun <= 1'b1;
        end else if (start && (state == S_IDLE)) begin
            err_underrun <= 1'b0;
        end
    end
`else
    assign err_underrun = 1'b0;
`endif

endmodule
